// File: rtl/lsb_stego_engine.sv
// -----------------------------------------------------------------------------
// lsb_stego_engine
//
// LSB steganography engine. It works in one of two modes:
//   - Embed:   writes message bits into the k least-significant bits of each
//              cover pixel.
//   - Extract: collects the k LSBs of each pixel back into message words.
// k can be 1, 2 or 4, and is chosen per run. A run is set up and started
// with a start/done handshake.
//
// All FIFO interfaces are first-word-fall-through. The pop and push strobes
// are combinational from the state and the FIFO heads. This gives zero
// latency and a peak rate of one pixel per cycle.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse; latches configuration (ignored while busy)
//   mode             0 = embed, 1 = extract
//   cfg_k            bits per pixel (1, 2, 4; anything else acts as 1)
//   msg_len          message words to embed / extract
//   num_pix          cover pixels to process (embed only)
//   busy             high from the cycle after start through the done cycle
//   done             one-cycle end-of-run pulse
//   err              message did not fit into num_pix pixels; sticky until start
//   ff_pixel_*       pixel FIFO head / empty / pop
//   ff_mess_*        message FIFO head / empty / pop
//   ff_full          output FIFO full
//   ff_data, ff_wr   output word and push
// -----------------------------------------------------------------------------
module lsb_stego_engine #(
  parameter int DATA_W = 8,
  parameter int MAX_K  = 4,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [2:0]        cfg_k,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic [CNT_W-1:0]  num_pix,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] ff_pixel_data,
  input  logic              ff_pixel_empty,
  output logic              ff_pixel_rd,
  input  logic [DATA_W-1:0] ff_mess_data,
  input  logic              ff_mess_empty,
  output logic              ff_mess_rd,
  input  logic              ff_full,
  output logic [DATA_W-1:0] ff_data,
  output logic              ff_wr
);

  // Wide enough to hold DATA_W itself. It serves as both the chunk counter
  // and the shift amount.
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PIXEL,
    S_EXTRACT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        k_q;
  logic [LEN_W-1:0]  words_left;  // embed: words not yet popped; extract: words not yet written
  logic [CNT_W-1:0]  pix_left;
  logic [DATA_W-1:0] msg_sr;
  logic [DATA_W-1:0] acc;
  logic [CW-1:0]     grp_cnt;     // chunks left in the current word, including the current one
  logic              msg_valid;   // msg_sr still holds unembedded bits
  logic              err_q;

  // Illegal or unsupported widths fall back to one bit per pixel.
  function automatic logic [2:0] decode_k(input logic [2:0] k);
    if ((k == 3'd1 || k == 3'd2 || k == 3'd4) && int'(k) <= MAX_K) return k;
    return 3'd1;
  endfunction

  // Number of k-bit chunks in one word. k is always a power of two, so this
  // is a small constant table instead of a divider.
  function automatic logic [CW-1:0] groups(input logic [2:0] k);
    case (k)
      3'd2:    return CW'(DATA_W / 2);
      3'd4:    return CW'(DATA_W / 4);
      default: return CW'(DATA_W);
    endcase
  endfunction

  logic [DATA_W-1:0] k_mask, chunk, acc_next;
  logic              last_chunk, last_pix, more_words;
  logic              pix_fire, err_set;

  always_comb begin
    k_mask     = ~({DATA_W{1'b1}} << k_q);
    chunk      = (msg_sr >> (CW'(DATA_W) - CW'(k_q))) & k_mask;
    acc_next   = (acc << k_q) | (ff_pixel_data & k_mask);
    last_chunk = (grp_cnt == CW'(1));
    last_pix   = (pix_left == CNT_W'(1));
    more_words = (words_left != '0);
  end

  // Next-state logic and FIFO strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. Without
    // these defaults, a path that does not assign a signal would infer a latch.
    state_d     = state_q;
    ff_pixel_rd = 1'b0;
    ff_mess_rd  = 1'b0;
    ff_wr       = 1'b0;
    ff_data     = '0;
    pix_fire    = 1'b0;
    err_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode) state_d = (msg_len == '0) ? S_DONE : S_EXTRACT;
          else      state_d = (num_pix == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        if (!more_words) begin
          state_d = S_PIXEL;               // pass-through for the remaining pixels
        end else if (!ff_mess_empty) begin
          ff_mess_rd = 1'b1;
          state_d    = S_PIXEL;
        end
      end

      S_PIXEL: begin
        if (!ff_pixel_empty && !ff_full) begin
          pix_fire    = 1'b1;
          ff_pixel_rd = 1'b1;
          ff_wr       = 1'b1;
          ff_data     = msg_valid ? ((ff_pixel_data & ~k_mask) | chunk) : ff_pixel_data;
          if (last_pix) begin
            state_d = S_DONE;
            // Message bits are left over: either part of msg_sr, or whole
            // words still waiting in the FIFO.
            err_set = (msg_valid && !last_chunk) || more_words;
          end else if (msg_valid && last_chunk && more_words) begin
            // Refill in the same cycle so there is no bubble between words.
            if (!ff_mess_empty) ff_mess_rd = 1'b1;
            else                state_d    = S_LOAD;
          end
        end
      end

      S_EXTRACT: begin
        // Only the pixel that completes a word needs room in the output FIFO.
        if (!ff_pixel_empty && (!last_chunk || !ff_full)) begin
          pix_fire    = 1'b1;
          ff_pixel_rd = 1'b1;
          if (last_chunk) begin
            ff_wr   = 1'b1;
            ff_data = acc_next;
            if (words_left == LEN_W'(1)) state_d = S_DONE;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only. Each register
  // then sees the pre-edge values of the others, whatever order the
  // statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counters and shift registers are cleared together with the
      // state. A run aborted by reset then leaves no stale bits behind.
      state_q    <= S_IDLE;
      k_q        <= 3'd1;
      words_left <= '0;
      pix_left   <= '0;
      msg_sr     <= '0;
      acc        <= '0;
      grp_cnt    <= '0;
      msg_valid  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_q        <= decode_k(cfg_k);
            words_left <= msg_len;
            pix_left   <= num_pix;
            grp_cnt    <= groups(decode_k(cfg_k));
            acc        <= '0;
            msg_valid  <= 1'b0;
            err_q      <= 1'b0;
          end
        end

        S_LOAD: begin
          if (ff_mess_rd) begin
            msg_sr     <= ff_mess_data;
            grp_cnt    <= groups(k_q);
            words_left <= words_left - LEN_W'(1);
            msg_valid  <= 1'b1;
          end
        end

        S_PIXEL: begin
          if (pix_fire) begin
            pix_left <= pix_left - CNT_W'(1);
            if (msg_valid) begin
              if (ff_mess_rd) begin
                msg_sr     <= ff_mess_data;
                grp_cnt    <= groups(k_q);
                words_left <= words_left - LEN_W'(1);
              end else begin
                msg_sr  <= msg_sr << k_q;
                grp_cnt <= grp_cnt - CW'(1);
                if (last_chunk) msg_valid <= 1'b0;
              end
            end
            if (err_set) err_q <= 1'b1;
          end
        end

        S_EXTRACT: begin
          if (pix_fire) begin
            acc <= acc_next;
            if (last_chunk) begin
              grp_cnt    <= groups(k_q);
              words_left <= words_left - LEN_W'(1);
            end else begin
              grp_cnt <= grp_cnt - CW'(1);
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_lsb_stego_engine.sv
// -----------------------------------------------------------------------------
// tb_lsb_stego_engine
//
// Self-checking bench for lsb_stego_engine.
//
// The three FIFOs are modelled as queues with first-word-fall-through
// behaviour. Expected output words are pushed to a scoreboard queue when a
// run is loaded, and popped and compared whenever the DUT pushes a word.
//
// Whole runs are described by a table of vectors. Hand-written sequences
// cover the following cases:
//   - backpressure from the output FIFO
//   - a pixel FIFO that goes empty mid-run
//   - reset asserted mid-run
// -----------------------------------------------------------------------------
module tb_lsb_stego_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [2:0]  cfg_k;
  logic [15:0] msg_len;
  logic [23:0] num_pix;
  logic        busy, done, err;
  logic [7:0]  ff_pixel_data;
  logic        ff_pixel_empty;
  logic        ff_pixel_rd;
  logic [7:0]  ff_mess_data;
  logic        ff_mess_empty;
  logic        ff_mess_rd;
  logic        ff_full;
  logic [7:0]  ff_data;
  logic        ff_wr;

  lsb_stego_engine #(
    .DATA_W(8), .MAX_K(4), .LEN_W(16), .CNT_W(24)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .cfg_k         (cfg_k),
    .msg_len       (msg_len),
    .num_pix       (num_pix),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .ff_pixel_data (ff_pixel_data),
    .ff_pixel_empty(ff_pixel_empty),
    .ff_pixel_rd   (ff_pixel_rd),
    .ff_mess_data  (ff_mess_data),
    .ff_mess_empty (ff_mess_empty),
    .ff_mess_rd    (ff_mess_rd),
    .ff_full       (ff_full),
    .ff_data       (ff_data),
    .ff_wr         (ff_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         mode;
    logic [2:0] k;
    int         msg_len;
    int         num_pix;
    int         n_msg;
    logic [7:0] msg [2];
    int         n_pix;
    logic [7:0] pix [8];
    int         n_exp;
    logic [7:0] exp_out [8];
    bit         exp_err;
    int         exp_mpops;
    int         exp_ppops;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] pix_q [$];
  logic [7:0] mess_q [$];
  logic [7:0] exp_q [$];
  logic       pix_block;
  int         n_checks;
  int         n_fail;
  int         pix_pops;
  int         mess_pops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present the FIFO heads to the DUT.
  task automatic refresh();
    ff_pixel_empty = pix_block || (pix_q.size() == 0);
    ff_pixel_data  = (pix_q.size() != 0) ? pix_q[0] : 8'h00;
    ff_mess_empty  = (mess_q.size() == 0);
    ff_mess_data   = (mess_q.size() != 0) ? mess_q[0] : 8'h00;
  endtask

  // FIFO model and scoreboard.
  // Strobes are sampled on the falling edge. The matching pops are applied
  // just after the rising edge at which the DUT consumed the data.
  initial begin
    bit do_pix, do_mess;
    forever begin
      @(negedge clk);
      do_pix  = ff_pixel_rd;
      do_mess = ff_mess_rd;
      if (ff_pixel_rd) begin
        pix_pops++;
        check("pix_rd_not_empty", ff_pixel_empty, 0);
      end
      if (ff_mess_rd) begin
        mess_pops++;
        check("mess_rd_not_empty", ff_mess_empty, 0);
      end
      if (ff_wr) begin
        check("wr_not_full", ff_full, 0);
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("out_word", ff_data, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (do_pix && pix_q.size() > 0)   void'(pix_q.pop_front());
      if (do_mess && mess_q.size() > 0) void'(mess_q.pop_front());
      refresh();
    end
  end

  task automatic load_run(input vec_t v);
    pix_q.delete();
    mess_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.n_pix; i++) pix_q.push_back(v.pix[i]);
    for (int i = 0; i < v.n_msg; i++) mess_q.push_back(v.msg[i]);
    for (int i = 0; i < v.n_exp; i++) exp_q.push_back(v.exp_out[i]);
    refresh();
  endtask

  task automatic start_run(input bit m, input logic [2:0] k, input int len, input int npix);
    @(posedge clk);
    #1;
    pix_pops  = 0;
    mess_pops = 0;
    start     = 1'b1;
    mode      = m;
    cfg_k     = k;
    msg_len   = len[15:0];
    num_pix   = npix[23:0];
    @(posedge clk);
    #1;
    // Scramble the configuration. The run must use the latched copy.
    start   = 1'b0;
    mode    = ~m;
    cfg_k   = 3'd7;
    msg_len = '1;
    num_pix = '1;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
  endtask

  task automatic finish_run(input string name, input bit e_err, input int e_mp, input int e_pp);
    int cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, done, 1);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 0);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_err"}, err, e_err);
    check({name, "_mess_pops"}, mess_pops, e_mp);
    check({name, "_pix_pops"}, pix_pops, e_pp);
    check({name, "_sb_drained"}, exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    load_run(v);
    start_run(v.mode, v.k, v.msg_len, v.num_pix);
    finish_run(v.name, v.exp_err, v.exp_mpops, v.exp_ppops);
  endtask

  initial begin
    vec_t        tmp;
    logic [7:0]  p;
    logic [15:0] msg_bits;

    n_checks = 0;
    n_fail   = 0;
    pix_pops = 0;
    mess_pops = 0;
    pix_block = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    cfg_k    = 3'd1;
    msg_len  = '0;
    num_pix  = '0;
    ff_full  = 1'b0;
    refresh();

    //           name          md k     len np nm msg             npix pix                                                    nexp exp                                                    err mp pp
    vecs[0]  = '{"emb_k1",     0, 3'd1, 1, 8, 1, '{8'h20, 8'h00}, 8, '{8'hE8,8'h52,8'h8E,8'h0A,8'h0A,8'h0A,8'h0A,8'h0A}, 8, '{8'hE8,8'h52,8'h8F,8'h0A,8'h0A,8'h0A,8'h0A,8'h0A}, 0, 1, 8};
    vecs[1]  = '{"emb_k2",     0, 3'd2, 1, 6, 1, '{8'hB4, 8'h00}, 6, '{8'hFF,8'hFF,8'hFF,8'hFF,8'h11,8'h11,8'h00,8'h00}, 6, '{8'hFE,8'hFF,8'hFD,8'hFC,8'h11,8'h11,8'h00,8'h00}, 0, 1, 6};
    vecs[2]  = '{"ext_k4",     1, 3'd4, 2, 0, 0, '{8'h00, 8'h00}, 6, '{8'h3A,8'hC5,8'h01,8'hF2,8'h77,8'h88,8'h00,8'h00}, 2, '{8'hA5,8'h12,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 4};
    vecs[3]  = '{"ovf_k1",     0, 3'd1, 1, 4, 1, '{8'hA5, 8'h00}, 4, '{8'h00,8'h00,8'hFF,8'hFF,8'h00,8'h00,8'h00,8'h00}, 4, '{8'h01,8'h00,8'hFF,8'hFE,8'h00,8'h00,8'h00,8'h00}, 1, 1, 4};
    vecs[4]  = '{"ovf_k2",     0, 3'd2, 2, 3, 2, '{8'h1B, 8'hE4}, 3, '{8'h80,8'h80,8'h80,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, '{8'h80,8'h81,8'h82,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 1, 3};
    vecs[5]  = '{"k3_as_k1",   0, 3'd3, 1, 8, 1, '{8'h20, 8'h00}, 8, '{8'hE8,8'h52,8'h8E,8'h0A,8'h0A,8'h0A,8'h0A,8'h0A}, 8, '{8'hE8,8'h52,8'h8F,8'h0A,8'h0A,8'h0A,8'h0A,8'h0A}, 0, 1, 8};
    vecs[6]  = '{"emb_k4_2w",  0, 3'd4, 2, 4, 2, '{8'h9C, 8'h3F}, 4, '{8'h00,8'hF0,8'h55,8'hAA,8'h00,8'h00,8'h00,8'h00}, 4, '{8'h09,8'hFC,8'h53,8'hAF,8'h00,8'h00,8'h00,8'h00}, 0, 2, 4};
    vecs[7]  = '{"pass_thru",  0, 3'd1, 0, 3, 0, '{8'h00, 8'h00}, 3, '{8'h01,8'h02,8'h03,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, '{8'h01,8'h02,8'h03,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 3};
    vecs[8]  = '{"emb_0pix",   0, 3'd1, 1, 0, 1, '{8'h55, 8'h00}, 1, '{8'h42,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 0};
    vecs[9]  = '{"ext_0len",   1, 3'd2, 0, 0, 0, '{8'h00, 8'h00}, 1, '{8'h42,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 0};
    vecs[10] = '{"ext_k1",     1, 3'd1, 1, 0, 0, '{8'h00, 8'h00}, 8, '{8'h01,8'hFF,8'h10,8'h0E,8'h20,8'h40,8'h81,8'h03}, 1, '{8'hC3,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 8};
    vecs[11] = '{"ext_k2",     1, 3'd2, 1, 0, 0, '{8'h00, 8'h00}, 4, '{8'h02,8'h03,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00}, 1, '{8'hB1,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 4};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wr", ff_wr, 0);
    check("rst_pix_rd", ff_pixel_rd, 0);
    check("rst_mess_rd", ff_mess_rd, 0);
    check("rst_data", ff_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven runs.
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: the output FIFO goes full mid-embed, then the pixel
    // FIFO runs dry. Uses k=1, two message words and 16 pixels.
    pix_q.delete();
    mess_q.delete();
    exp_q.delete();
    msg_bits = 16'h5AC3;
    for (int i = 0; i < 16; i++) begin
      p = 8'(i * 37 + 5);
      pix_q.push_back(p);
      exp_q.push_back({p[7:1], msg_bits[15-i]});
    end
    mess_q.push_back(8'h5A);
    mess_q.push_back(8'hC3);
    refresh();
    start_run(1'b0, 3'd1, 2, 16);
    repeat (3) @(posedge clk);
    #1 ff_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_full_no_wr", ff_wr, 0);
      check("bp_full_no_rd", ff_pixel_rd, 0);
      check("bp_full_busy", busy, 1);
    end
    @(posedge clk);
    #1 ff_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pix_block = 1'b1;
    refresh();
    repeat (3) begin
      @(negedge clk);
      check("bp_empty_no_wr", ff_wr, 0);
      check("bp_empty_no_rd", ff_pixel_rd, 0);
    end
    @(posedge clk);
    #1;
    pix_block = 1'b0;
    refresh();
    finish_run("backpressure", 1'b0, 2, 16);

    // Reset asserted in the middle of an embed run.
    load_run(vecs[0]);
    start_run(1'b0, 3'd1, 1, 8);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_wr", ff_wr, 0);
    check("midrst_pix_rd", ff_pixel_rd, 0);
    check("midrst_mess_rd", ff_mess_rd, 0);
    check("midrst_data", ff_data, 0);
    pix_q.delete();
    mess_q.delete();
    exp_q.delete();
    refresh();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tmp      = vecs[0];
    tmp.name = "after_reset";
    run_vec(tmp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
